mem_stage: RTL

- Pipeline MEM stage: sits between EX and the write-back stage.
- Takes one instruction from EX over a valid/ready bus and performs at most one data-memory access (load or store, byte/half/word).
- Hands a packed {regData, regAddr, regW} bus to WB over valid/ready.
- Non-memory instructions pass straight through with zero-bubble throughput.

---
 rtl/mem_stage.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage between EX and write-back. It accepts one
//            instruction from EX and performs at most one data-memory access
//            (load/store, byte/half/word). It then hands {regData, regAddr,
//            regW} to WB. Non-memory instructions pass through with one
//            cycle of latency and no bubbles.
// Ports    : clk, rst (async, active-high)
//            ex_to_mem_bus/valid, mem_to_ex_ready      - EX side handshake
//            mem_to_wb_bus/valid, wb_to_mem_ready      - WB side handshake
//            dmem_req_* / dmem_rsp_*                   - data memory port
//            misalign_err                              - one-cycle pulse
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [2*DATA_WIDTH+ADDR_WIDTH+5:0]    ex_to_mem_bus,
    input  logic                                  ex_to_mem_valid,
    output logic                                  mem_to_ex_ready,
    output logic [DATA_WIDTH+ADDR_WIDTH:0]        mem_to_wb_bus,
    output logic                                  mem_to_wb_valid,
    input  logic                                  wb_to_mem_ready,
    output logic                                  dmem_req_valid,
    input  logic                                  dmem_req_ready,
    output logic                                  dmem_req_wen,
    output logic [DATA_WIDTH-1:0]                 dmem_req_addr,
    output logic [DATA_WIDTH-1:0]                 dmem_req_wdata,
    output logic [3:0]                            dmem_req_wstrb,
    input  logic                                  dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                 dmem_rsp_rdata,
    output logic                                  misalign_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    localparam int c_ALU_LSB = ADDR_WIDTH + 1;
    localparam int c_SD_LSB  = ADDR_WIDTH + 1 + DATA_WIDTH;
    localparam int c_CTL_LSB = ADDR_WIDTH + 1 + 2*DATA_WIDTH;

    // Incoming EX fields
    logic                  w_in_regw;
    logic [ADDR_WIDTH-1:0] w_in_regaddr;
    logic [DATA_WIDTH-1:0] w_in_alu;
    logic [DATA_WIDTH-1:0] w_in_sdata;
    logic                  w_in_memr;
    logic                  w_in_memw;
    logic [1:0]            w_in_size;
    logic                  w_in_uns;
    logic                  w_in_mem;
    logic                  w_in_misalign;
    logic                  w_accept;

    // Latched instruction
    logic [1:0]            r_state;
    logic                  r_regw;
    logic [ADDR_WIDTH-1:0] r_regaddr;
    logic [DATA_WIDTH-1:0] r_regdata;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_sdata;
    logic                  r_memw;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic                  r_misalign_err;

    logic [4:0]            w_shamt;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign w_in_regw    = ex_to_mem_bus[0];
    assign w_in_regaddr = ex_to_mem_bus[ADDR_WIDTH:1];
    assign w_in_alu     = ex_to_mem_bus[c_ALU_LSB +: DATA_WIDTH];
    assign w_in_sdata   = ex_to_mem_bus[c_SD_LSB +: DATA_WIDTH];
    assign w_in_memr    = ex_to_mem_bus[c_CTL_LSB];
    assign w_in_memw    = ex_to_mem_bus[c_CTL_LSB+1];
    assign w_in_size    = ex_to_mem_bus[c_CTL_LSB+3:c_CTL_LSB+2];
    assign w_in_uns     = ex_to_mem_bus[c_CTL_LSB+4];
    assign w_in_mem     = w_in_memr | w_in_memw;

    // Size encodings 10 and 11 are both treated as word accesses
    assign w_in_misalign = (w_in_size == 2'b01 && w_in_alu[0]) ||
                           (w_in_size[1] && w_in_alu[1:0] != 2'b00);

    // In OUT the stage can refill in the same cycle WB drains it
    assign mem_to_ex_ready = (r_state == c_IDLE) ||
                             (r_state == c_OUT && wb_to_mem_ready);
    assign w_accept        = ex_to_mem_valid && mem_to_ex_ready;

    assign mem_to_wb_valid = (r_state == c_OUT);
    assign mem_to_wb_bus   = {r_regdata, r_regaddr, r_regw};
    assign misalign_err    = r_misalign_err;

    // Request fields are derived from latched state, so they stay stable
    // for the whole time dmem_req_valid is waiting on dmem_req_ready.
    assign dmem_req_valid = (r_state == c_REQ);
    assign dmem_req_wen   = r_memw;
    assign dmem_req_addr  = {r_addr[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        dmem_req_wdata = r_sdata;
        dmem_req_wstrb = 4'b0000;
        case (r_size)
            2'b00: begin
                dmem_req_wdata = {4{r_sdata[7:0]}};
                dmem_req_wstrb = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                dmem_req_wdata = {2{r_sdata[15:0]}};
                dmem_req_wstrb = 4'b0011 << r_addr[1:0];
            end
            default: begin
                dmem_req_wdata = r_sdata;
                dmem_req_wstrb = 4'b1111;
            end
        endcase
        if (!r_memw) begin
            dmem_req_wstrb = 4'b0000;
        end
    end

    // Move the addressed lane down to bit 0, then extend
    assign w_shamt   = {r_addr[1:0], 3'b000};
    assign w_shifted = dmem_rsp_rdata >> w_shamt;

    always_comb begin
        w_load_data = w_shifted;
        case (r_size)
            2'b00:   w_load_data = r_uns ? {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]}
                                         : {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = r_uns ? {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]}
                                         : {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_regw         <= 1'b0;
            r_regaddr      <= '0;
            r_regdata      <= '0;
            r_addr         <= '0;
            r_sdata        <= '0;
            r_memw         <= 1'b0;
            r_size         <= 2'b00;
            r_uns          <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= 1'b0;
            if (w_accept) begin
                r_regaddr <= w_in_regaddr;
                r_regdata <= w_in_alu;
                r_addr    <= w_in_alu;
                r_sdata   <= w_in_sdata;
                r_memw    <= w_in_memw;
                r_size    <= w_in_size;
                r_uns     <= w_in_uns;
                if (w_in_mem && w_in_misalign) begin
                    // Drop the access; WB sees the address with no write
                    r_regw         <= 1'b0;
                    r_misalign_err <= 1'b1;
                    r_state        <= c_OUT;
                end else if (w_in_mem) begin
                    r_regw  <= w_in_regw;
                    r_state <= c_REQ;
                end else begin
                    r_regw  <= w_in_regw;
                    r_state <= c_OUT;
                end
            end else begin
                case (r_state)
                    c_REQ: begin
                        if (dmem_req_ready) begin
                            r_state <= c_RESP;
                        end
                    end
                    c_RESP: begin
                        if (dmem_rsp_valid) begin
                            if (r_memw) begin
                                r_regw <= 1'b0;
                            end else begin
                                r_regdata <= w_load_data;
                            end
                            r_state <= c_OUT;
                        end
                    end
                    c_OUT: begin
                        if (wb_to_mem_ready) begin
                            r_state <= c_IDLE;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
